// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: fetches 64-byte lines into a byte ring and presents a 15-byte decode window.
// Optional redirect support (redirect/redirect_addr ports, DRAIN state) under FETCH_REDIRECT_EN.
module fetch_byte_queue #(
    parameter int          BUF_LINES = 2,
    parameter logic [12:0] REQ_TAG   = 13'h1100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   entry,
    output logic          reqcyc,
    input  logic          reqack,
    output logic [63:0]   req,
    output logic [12:0]   reqtag,
    input  logic          respcyc,
    output logic          respack,
    input  logic [63:0]   resp,
    output logic [119:0]  win_bytes,
    output logic [3:0]    win_avail,
    output logic [63:0]   win_addr,
    input  logic [3:0]    consume
`ifdef FETCH_REDIRECT_EN
    ,
    input  logic          redirect,
    input  logic [63:0]   redirect_addr
`endif
);
    localparam int RING = 64 * BUF_LINES;
    localparam int AW   = $clog2(RING);
    localparam int LB   = $clog2(BUF_LINES);

    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] idx_t;
    typedef logic [LB:0]   slot_t;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;

    state_t      state_q;
    logic        reqcyc_q;
    logic [63:0] req_q;
    logic [63:0] fetch_addr_q;
    logic [5:0]  skip_q;
    logic        first_q;
    logic [2:0]  beat_q;
    slot_t       wr_slot_q;
    logic        drain_pend_q;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        occ_q, occ_d;
    logic [63:0] win_addr_q, win_addr_d;
    logic [7:0]  mem_q [RING];

    logic        redir;
    logic [63:0] redir_addr;
    slot_t       slot_diff;
    logic        slot_free;
    logic        wr_en;
    logic [6:0]  beat_lo;
    logic [3:0]  bv;

`ifdef FETCH_REDIRECT_EN
    assign redir      = redirect;
    assign redir_addr = redirect_addr;
`else
    assign redir      = 1'b0;
    assign redir_addr = 64'd0;
`endif

    // Slot distance in wrap-bit arithmetic; MSB set means the ring is full.
    assign slot_diff = wr_slot_q - rd_ptr_q[AW:6];
    assign slot_free = ~slot_diff[LB];

    assign wr_en   = (state_q == RECV) && respcyc && !redir;
    assign beat_lo = {1'b0, beat_q, 3'b000};

    always_comb begin
        bv = 4'd0;
        if (wr_en) begin
            if (!first_q || beat_lo >= {1'b0, skip_q})
                bv = 4'd8;
            else if ({1'b0, skip_q} < beat_lo + 7'd8)
                bv = 4'(beat_lo + 7'd8 - {1'b0, skip_q});
        end
    end

    always_comb begin
        occ_d      = occ_q + ptr_t'(bv) - ptr_t'(consume);
        rd_ptr_d   = rd_ptr_q + ptr_t'(consume);
        win_addr_d = win_addr_q + 64'(consume);
        if (redir) begin
            occ_d      = '0;
            rd_ptr_d   = ptr_t'(redir_addr[5:0]);
            win_addr_d = redir_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= '0;
            rd_ptr_q   <= ptr_t'(entry[5:0]);
            win_addr_q <= entry;
        end else begin
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            win_addr_q <= win_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++)
                mem_q[{wr_slot_q[LB-1:0], beat_q, 3'(b)}] <= resp[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            reqcyc_q     <= 1'b0;
            req_q        <= '0;
            fetch_addr_q <= {entry[63:6], 6'd0};
            skip_q       <= entry[5:0];
            first_q      <= 1'b1;
            beat_q       <= '0;
            wr_slot_q    <= '0;
            drain_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (slot_free && !redir) begin
                        state_q  <= REQ;
                        reqcyc_q <= 1'b1;
                        req_q    <= fetch_addr_q;
                    end
                end
                REQ: begin
                    if (reqack) begin
                        reqcyc_q     <= 1'b0;
                        beat_q       <= '0;
                        drain_pend_q <= 1'b0;
                        state_q      <= (redir || drain_pend_q) ? DRAIN : RECV;
                    end else if (redir) begin
                        drain_pend_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (respcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            state_q      <= IDLE;
                            wr_slot_q    <= wr_slot_q + slot_t'(1);
                            fetch_addr_q <= fetch_addr_q + 64'd64;
                            first_q      <= 1'b0;
                        end else if (redir) begin
                            state_q <= DRAIN;
                        end
                    end else if (redir) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (respcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) state_q <= IDLE;
                    end
                end
            endcase
            // Redirect restarts the stream and overrides any line-completion update.
            if (redir) begin
                wr_slot_q    <= '0;
                fetch_addr_q <= {redir_addr[63:6], 6'd0};
                skip_q       <= redir_addr[5:0];
                first_q      <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 15; i++)
            win_bytes[8*i +: 8] = mem_q[idx_t'(rd_ptr_q[AW-1:0] + idx_t'(i))];
    end

    assign win_avail = (occ_q >= ptr_t'(15)) ? 4'd15 : occ_q[3:0];
    assign win_addr  = win_addr_q;
    assign reqcyc    = reqcyc_q;
    assign req       = req_q;
    assign reqtag    = REQ_TAG;
    assign respack   = respcyc;

`ifndef SYNTHESIS
    a_consume: assert property (@(posedge clk) disable iff (reset)
        redir || (consume <= win_avail))
        else $fatal(1, "consume exceeds win_avail");
    a_resp: assert property (@(posedge clk) disable iff (reset)
        respcyc |-> (state_q == RECV || state_q == DRAIN))
        else $fatal(1, "respcyc outside a receive phase");
`endif
endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: vector table of start PCs plus hand sequences.
// Bus model answers each request with bytes equal to the low address byte.
module tb_fetch_byte_queue;
    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   entry;
    logic          reqcyc;
    logic          reqack;
    logic [63:0]   req;
    logic [12:0]   reqtag;
    logic          respcyc;
    logic          respack;
    logic [63:0]   resp;
    logic [119:0]  win_bytes;
    logic [3:0]    win_avail;
    logic [63:0]   win_addr;
    logic [3:0]    consume;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_req_q[$];

    fetch_byte_queue #(.BUF_LINES(2), .REQ_TAG(13'h1100)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .reqcyc(reqcyc), .reqack(reqack), .req(req), .reqtag(reqtag),
        .respcyc(respcyc), .respack(respack), .resp(resp),
        .win_bytes(win_bytes), .win_avail(win_avail), .win_addr(win_addr),
        .consume(consume)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] pc;
        int          nbeats;
        int          avail;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_win(input string nm, input logic [63:0] a, input int av);
        logic [119:0] m;
        logic [119:0] e;
        m = '0;
        e = '0;
        for (int i = 0; i < 15; i++) begin
            if (i < av) begin
                m[8*i +: 8] = 8'hFF;
                e[8*i +: 8] = 8'(a + 64'(i));
            end
        end
        chk({nm, "_avail"}, 128'(win_avail), 128'(av));
        chk({nm, "_addr"}, 128'(win_addr), 128'(a));
        if (av > 0) chk({nm, "_bytes"}, 128'(win_bytes & m), 128'(e));
    endtask

    function automatic logic [63:0] beat_data(input logic [63:0] a, input int k);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(a + 64'(8*k + i));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset   = 1'b1;
        entry   = e;
        consume = '0;
        respcyc = 1'b0;
        reqack  = 1'b0;
        resp    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!reqcyc && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic serve(input int nbeats);
        logic [63:0] a;
        wait_req();
        chk("req_seen", 128'(reqcyc), 128'(1));
        if (!reqcyc) return;
        a = exp_req_q.pop_front();
        chk("req_addr", 128'(req), 128'(a));
        chk("reqtag", 128'(reqtag), 128'(13'h1100));
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        chk("reqcyc_drop", 128'(reqcyc), 128'(0));
        for (int k = 0; k < nbeats; k++) begin
            respcyc = 1'b1;
            resp    = beat_data(a, k);
            tick();
        end
        respcyc = 1'b0;
        resp    = '0;
    endtask

    task automatic eat(input int n);
        consume = 4'(n);
        tick();
        consume = '0;
    endtask

    vec_t vecs[10];
    logic seen;

    initial begin
        vecs[0] = '{64'h1000, 1, 8};
        vecs[1] = '{64'h1000, 2, 15};
        vecs[2] = '{64'h100B, 1, 0};
        vecs[3] = '{64'h100B, 2, 5};
        vecs[4] = '{64'h100B, 3, 13};
        vecs[5] = '{64'h100B, 4, 15};
        vecs[6] = '{64'h103F, 7, 0};
        vecs[7] = '{64'h103F, 8, 1};
        vecs[8] = '{64'h1020, 5, 8};
        vecs[9] = '{64'h1030, 8, 15};

        // Reset state and aligned start
        do_reset(64'h1000);
        chk("rst_reqcyc", 128'(reqcyc), 128'(0));
        chk("rst_req", 128'(req), 128'(0));
        chk_win("rst", 64'h1000, 0);
        chk("rst_respack", 128'(respack), 128'(0));
        exp_req_q.push_back(64'h1000);
        serve(8);
        chk_win("aligned", 64'h1000, 15);
        chk("aligned_b0", 128'(win_bytes[7:0]), 128'(8'h00));
        chk("aligned_b14", 128'(win_bytes[119:112]), 128'(8'h0E));

        // Start PCs versus beats delivered; a partial line is cut by the next reset
        for (int v = 0; v < 10; v++) begin
            do_reset(vecs[v].pc);
            exp_req_q.push_back({vecs[v].pc[63:6], 6'd0});
            serve(vecs[v].nbeats);
            chk_win($sformatf("vec%0d", v), vecs[v].pc, vecs[v].avail);
        end

        // Unaligned start: 53 bytes valid from the first line
        do_reset(64'h100B);
        exp_req_q.push_back(64'h1000);
        serve(8);
        chk_win("unal", 64'h100B, 15);
        chk("unal_b0", 128'(win_bytes[7:0]), 128'(8'h0B));
        eat(15);
        eat(15);
        eat(15);
        chk_win("unal_tail", 64'h1038, 8);
        eat(8);
        chk_win("unal_empty", 64'h1040, 0);

        // Backpressure and reset while a request is pending
        do_reset(64'h1000);
        wait_req();
        for (int c = 0; c < 5; c++) begin
            chk("bp_reqcyc", 128'(reqcyc), 128'(1));
            chk("bp_req", 128'(req), 128'(64'h1000));
            tick();
        end
        reqack = 1'b1;
        tick();
        reqack = 1'b0;
        chk("bp_drop", 128'(reqcyc), 128'(0));
        reset = 1'b1;
        #1;
        chk("midrecv_rst_win", 128'(win_avail), 128'(0));
        tick();
        reset = 1'b0;
        wait_req();
        reset = 1'b1;
        #1;
        chk("midreq_rst_reqcyc", 128'(reqcyc), 128'(0));
        chk("midreq_rst_req", 128'(req), 128'(0));
        tick();

        // Ring full: two lines then stall until the oldest slot is consumed
        do_reset(64'h1000);
        exp_req_q.push_back(64'h1000);
        serve(8);
        exp_req_q.push_back(64'h1040);
        serve(8);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (reqcyc) seen = 1'b1;
        end
        chk("full_no_req", 128'(seen), 128'(0));
        for (int c = 0; c < 4; c++) eat(15);
        chk_win("full_60", 64'h103C, 15);
        eat(4);
        chk("full_still_idle", 128'(reqcyc), 128'(0));
        tick();
        chk("full_third_req", 128'(reqcyc), 128'(1));
        chk("full_third_addr", 128'(req), 128'(64'h1080));

        // Window wrapping past the end of the ring
        exp_req_q.push_back(64'h1080);
        serve(8);
        eat(15);
        eat(15);
        eat(15);
        eat(11);
        chk_win("wrap", 64'h1078, 15);
        chk("wrap_b7", 128'(win_bytes[63:56]), 128'(8'h7F));
        chk("wrap_b8", 128'(win_bytes[71:64]), 128'(8'h80));
        chk("wrap_no_req", 128'(reqcyc), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
